// File: rtl/shift_chain_loopback_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// shift_chain_loopback_ctrl_pkg
//   Shared definitions for the shift-chain loopback controller:
//   - state_t : controller FSM encoding (2-bit, IDLE/RUN/DONE)
//   - cyc_w   : width of the per-transfer cycle counter, wide enough to hold
//               DEPTH+WIDTH without wrapping
//   - idx_w   : width of a bit index into a WIDTH-bit word (minimum 1)
// -----------------------------------------------------------------------------
package shift_chain_loopback_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic int cyc_w(input int depth, input int width);
      return $clog2(depth + width + 1);
   endfunction

   function automatic int idx_w(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/shift_chain_loopback_ctrl_sipo_capture.sv
// -----------------------------------------------------------------------------
// sipo_capture
//   Serial-in / parallel-out capture register for the returning chain bits.
//   When en is high, ser_in is written into bit position idx (mapped through
//   LSB_FIRST) at the end of the cycle.
// Ports
//   clk      in   1      rising-edge clock
//   rst_n    in   1      asynchronous active-low reset (clears the word)
//   en       in   1      capture ser_in this cycle
//   idx      in   IDX_W  arrival order of the bit (0 = first received)
//   ser_in   in   1      serial bit from the chain output
//   rx_word  out  WIDTH  captured word including the bit being sampled now,
//                        so the owner can register the complete word on the
//                        same edge that stores the final bit
// -----------------------------------------------------------------------------
module sipo_capture
   import shift_chain_loopback_ctrl_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int LSB_FIRST = 1,
   parameter int IDX_W     = idx_w(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [IDX_W-1:0] idx,
   input  logic             ser_in,
   output logic [WIDTH-1:0] rx_word
);

   logic [WIDTH-1:0] rx;
   logic [IDX_W-1:0] pos;

   // Arrival order -> word bit position.
   always_comb begin
      pos = idx;
      if (LSB_FIRST == 0) begin
         pos = IDX_W'(WIDTH - 1) - idx;
      end
   end

   always_comb begin
      rx_word = rx;
      if (en) begin
         rx_word[pos] = ser_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx <= '0;
      end else begin
         rx <= rx_word;
      end
   end

endmodule

// File: rtl/shift_chain_loopback_ctrl.sv
// -----------------------------------------------------------------------------
// shift_chain_loopback_ctrl
//   Sequencer for a free-running DEPTH-stage serial shift chain. A parallel
//   word is accepted, serialised onto the chain input one bit per clock, and
//   the bits returning DEPTH clocks later are reassembled into a result word.
//   The result is compared with the sent word and a mismatch flag is raised.
// Ports
//   clk        in   1      rising-edge clock, shared with the chain
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      input word valid
//   in_ready   out  1      controller can accept a word (IDLE only)
//   in_data    in   WIDTH  word to send
//   abort      in   1      synchronous cancel of the current transfer
//   ser_out    out  1      registered serial bit to the chain input
//   shift_en   out  1      high while ser_out carries payload
//   ser_in     in   1      serial bit from the chain output
//   out_valid  out  1      result word valid (DONE)
//   out_ready  in   1      consumer accepts result
//   out_data   out  WIDTH  received word
//   mismatch   out  1      out_data differs from the sent word
//   busy       out  1      controller not in IDLE
//   state_dbg  out  2      current FSM state (state_t encoding)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. valid never depends on ready. in_ready is high only in IDLE;
// out_valid is high only in DONE and holds out_data/mismatch stable until the
// transfer (or an abort). There is no bypass: a new word cannot be accepted
// on the same edge as the result handshake.
// -----------------------------------------------------------------------------
module shift_chain_loopback_ctrl
   import shift_chain_loopback_ctrl_pkg::*;
#(
   parameter int   WIDTH     = 8,
   parameter int   DEPTH     = 10,
   parameter int   LSB_FIRST = 1,
   parameter logic IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             abort,
   output logic             ser_out,
   output logic             shift_en,
   input  logic             ser_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             mismatch,
   output logic             busy,
   output logic [1:0]       state_dbg
);

   localparam int CYC_W = cyc_w(DEPTH, WIDTH);
   localparam int IDX_W = idx_w(WIDTH);

   localparam logic [CYC_W-1:0] DEPTH_C   = CYC_W'(DEPTH);
   localparam logic [CYC_W-1:0] WIDTH_C   = CYC_W'(WIDTH);
   localparam logic [CYC_W-1:0] CAP_END_C = CYC_W'(DEPTH + WIDTH);
   localparam logic [CYC_W-1:0] LAST_C    = CYC_W'(DEPTH + WIDTH - 1);

   state_t           state;
   logic [CYC_W-1:0] cyc;
   logic [CYC_W-1:0] cyc_nxt;
   logic [WIDTH-1:0] tx;
   logic [WIDTH-1:0] sent;
   logic [WIDTH-1:0] rx_word;
   logic             cap_en;
   logic [IDX_W-1:0] cap_idx;
   logic             first_bit;
   logic [WIDTH-1:0] tx_load;
   logic             tx_head;
   logic [WIDTH-1:0] tx_shift;

   assign state_dbg = state;
   assign cyc_nxt   = cyc + CYC_W'(1);

   // Capture window runs independently of the send window; the two overlap
   // when DEPTH < WIDTH.
   assign cap_en  = (state == ST_RUN) && (cyc >= DEPTH_C) && (cyc < CAP_END_C);
   assign cap_idx = IDX_W'(cyc - DEPTH_C);

   // PISO: the first bit goes straight to ser_out on the accept edge, the
   // remaining bits are held in tx and shifted towards the head position.
   always_comb begin
      if (LSB_FIRST != 0) begin
         first_bit = in_data[0];
         tx_load   = in_data >> 1;
         tx_head   = tx[0];
         tx_shift  = tx >> 1;
      end else begin
         first_bit = in_data[WIDTH-1];
         tx_load   = in_data << 1;
         tx_head   = tx[WIDTH-1];
         tx_shift  = tx << 1;
      end
   end

   sipo_capture #(
      .WIDTH     (WIDTH),
      .LSB_FIRST (LSB_FIRST),
      .IDX_W     (IDX_W)
   ) u_capture (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (cap_en),
      .idx     (cap_idx),
      .ser_in  (ser_in),
      .rx_word (rx_word)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cyc       <= '0;
         tx        <= '0;
         sent      <= '0;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
         ser_out   <= IDLE_BIT;
         shift_en  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         mismatch  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               // abort is ignored while idle
               if (in_valid) begin
                  state    <= ST_RUN;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  sent     <= in_data;
                  tx       <= tx_load;
                  cyc      <= '0;
                  ser_out  <= first_bit;
                  shift_en <= 1'b1;
               end
            end

            ST_RUN: begin
               if (abort) begin
                  state     <= ST_IDLE;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  out_valid <= 1'b0;
                  shift_en  <= 1'b0;
                  ser_out   <= IDLE_BIT;
                  mismatch  <= 1'b0;
               end else begin
                  // cyc ends at DEPTH+WIDTH and stays there through DONE.
                  cyc <= cyc_nxt;
                  // ser_out for the next cycle (cyc+1)
                  if (cyc_nxt < WIDTH_C) begin
                     ser_out  <= tx_head;
                     tx       <= tx_shift;
                     shift_en <= 1'b1;
                  end else begin
                     ser_out  <= IDLE_BIT;
                     shift_en <= 1'b0;
                  end
                  if (cyc == LAST_C) begin
                     state     <= ST_DONE;
                     out_valid <= 1'b1;
                     out_data  <= rx_word;
                     mismatch  <= (rx_word != sent);
                  end
               end
            end

            ST_DONE: begin
               // abort takes priority over a simultaneous output handshake
               if (abort) begin
                  state     <= ST_IDLE;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  out_valid <= 1'b0;
                  shift_en  <= 1'b0;
                  ser_out   <= IDLE_BIT;
                  mismatch  <= 1'b0;
               end else if (out_ready) begin
                  state     <= ST_IDLE;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  out_valid <= 1'b0;
               end
            end

            default: begin
               state     <= ST_IDLE;
               in_ready  <= 1'b1;
               busy      <= 1'b0;
               out_valid <= 1'b0;
               shift_en  <= 1'b0;
               ser_out   <= IDLE_BIT;
               mismatch  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_chain_loopback_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shift_chain_loopback_ctrl
//   Bench for shift_chain_loopback_ctrl with a 10-stage chain, WIDTH=8,
//   LSB first. The chain is a plain shift register; inject flips the chain
//   output for one cycle to model a corrupted stage.
// -----------------------------------------------------------------------------
module tb_shift_chain_loopback_ctrl;

   localparam int WIDTH = 8;
   localparam int DEPTH = 10;
   localparam int LAT   = DEPTH + WIDTH + 1;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             abort;
   logic             ser_out;
   logic             shift_en;
   logic             ser_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             mismatch;
   logic             busy;
   logic [1:0]       state_dbg;

   logic [DEPTH-1:0] chain;
   logic             inject;

   int n_checks = 0;
   int n_fail   = 0;
   logic [WIDTH-1:0] exp_q[$];

   // ---------------- clock / reset / chain ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial chain = '0;
   always @(posedge clk) chain <= {chain[DEPTH-2:0], ser_out};
   assign ser_in = chain[DEPTH-1] ^ inject;

   shift_chain_loopback_ctrl #(
      .WIDTH     (WIDTH),
      .DEPTH     (DEPTH),
      .LSB_FIRST (1),
      .IDLE_BIT  (1'b0)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .abort     (abort),
      .ser_out   (ser_out),
      .shift_en  (shift_en),
      .ser_in    (ser_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .mismatch  (mismatch),
      .busy      (busy),
      .state_dbg (state_dbg)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits for in_ready, offers one word, then follows the transfer cycle by
   // cycle (c = 0 is the first cycle after the accept edge). Checks the
   // serial stream, flips the chain output at flip_c, raises abort at abort_c
   // or pulses reset at rst_c. lat = edges from accept (inclusive) to
   // out_valid, -1 if out_valid never came.
   task automatic xfer(input logic [WIDTH-1:0] data, input int flip_c,
                       input int abort_c, input int rst_c, output int lat);
      int n;
      lat = -1;
      n = 0;
      while (!in_ready && n < 40) begin
         tick();
         n++;
      end
      chk("wait_in_ready", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_data  = data;
      tick();
      in_valid = 1'b0;
      in_data  = WIDTH'($urandom_range(0, 255));
      chk("accepted", {31'd0, busy}, 32'd1);
      for (int c = 0; c < 60; c++) begin
         if (out_valid) begin
            lat = c + 1;
            break;
         end
         if (c < WIDTH) chk($sformatf("ser_bit%0d", c), {30'd0, shift_en, ser_out}, {30'd0, 1'b1, data[c]});
         if (c == WIDTH) chk("ser_idle", {30'd0, shift_en, ser_out}, 32'd0);
         if (c == rst_c) begin
            #2 rst_n = 1'b0;
            #1;
            return;
         end
         if (c == abort_c) begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
            return;
         end
         inject = (c == flip_c);
         tick();
         inject = 1'b0;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int lat;
      int hits;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      abort     = 1'b0;
      out_ready = 1'b1;
      inject    = 1'b0;
      #23 rst_n = 1'b1;

      // 1: reset values after release
      repeat (5) tick();
      chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
      chk("rst_ser_out",   {31'd0, ser_out},   32'd0);
      chk("rst_shift_en",  {31'd0, shift_en},  32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_busy",      {31'd0, busy},      32'd0);
      chk("rst_out_data",  {24'd0, out_data},  32'd0);
      chk("rst_mismatch",  {31'd0, mismatch},  32'd0);
      chk("rst_state",     {30'd0, state_dbg}, 32'd0);

      // abort in IDLE is ignored
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("idle_abort_ready", {31'd0, in_ready}, 32'd1);
      chk("idle_abort_busy",  {31'd0, busy},     32'd0);

      // 2: clean round trip of A5, latency check, in_ready one clk later
      exp_q.push_back(8'hA5);
      xfer(8'hA5, -1, -1, -1, lat);
      chk("a5_latency", lat, LAT);
      chk("a5_data",    {24'd0, out_data}, {24'd0, exp_q.pop_front()});
      chk("a5_mismatch", {31'd0, mismatch}, 32'd0);
      chk("a5_ready_in_done", {31'd0, in_ready}, 32'd0);
      tick();
      chk("a5_in_ready_after", {31'd0, in_ready}, 32'd1);
      chk("a5_ov_dropped", {31'd0, out_valid}, 32'd0);

      // 3: 3C with the chain output flipped at c=12 -> bit 2 inverted
      exp_q.push_back(8'h38);
      xfer(8'h3C, 12, -1, -1, lat);
      chk("3c_latency", lat, LAT);
      chk("3c_data",    {24'd0, out_data}, {24'd0, exp_q.pop_front()});
      chk("3c_mismatch", {31'd0, mismatch}, 32'd1);
      tick();

      // 4: 01 held in DONE while a second word waits, then FF
      out_ready = 1'b0;
      exp_q.push_back(8'h01);
      xfer(8'h01, -1, -1, -1, lat);
      chk("01_latency", lat, LAT);
      in_valid = 1'b1;
      in_data  = 8'hFF;
      for (int i = 0; i < 7; i++) begin
         chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
         chk("hold_out_data",  {24'd0, out_data},  {24'd0, exp_q[0]});
         chk("hold_in_ready",  {31'd0, in_ready},  32'd0);
         tick();
      end
      chk("01_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
      chk("01_mismatch", {31'd0, mismatch}, 32'd0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("01_hs_out_valid", {31'd0, out_valid}, 32'd0);
      chk("01_hs_in_ready",  {31'd0, in_ready},  32'd1);
      exp_q.push_back(8'hFF);
      xfer(8'hFF, -1, -1, -1, lat);
      chk("ff_latency", lat, LAT);
      chk("ff_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
      chk("ff_mismatch", {31'd0, mismatch}, 32'd0);
      tick();

      // 5: abort at c=4 of 5A, then C3 round trips clean
      xfer(8'h5A, -1, 4, -1, lat);
      chk("abort_state",    {30'd0, state_dbg}, 32'd0);
      chk("abort_shift_en", {31'd0, shift_en},  32'd0);
      chk("abort_ser_out",  {31'd0, ser_out},   32'd0);
      chk("abort_in_ready", {31'd0, in_ready},  32'd1);
      hits = 0;
      for (int i = 0; i < 25; i++) begin
         if (out_valid) hits++;
         tick();
      end
      chk("abort_no_out_valid", hits, 0);
      exp_q.push_back(8'hC3);
      xfer(8'hC3, -1, -1, -1, lat);
      chk("c3_latency", lat, LAT);
      chk("c3_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
      chk("c3_mismatch", {31'd0, mismatch}, 32'd0);
      tick();

      // abort in DONE beats out_ready; out_data kept, mismatch cleared
      out_ready = 1'b0;
      exp_q.push_back(8'h76);
      xfer(8'h77, 10, -1, -1, lat);
      chk("77_mismatch", {31'd0, mismatch}, 32'd1);
      abort     = 1'b1;
      out_ready = 1'b1;
      tick();
      abort = 1'b0;
      chk("done_abort_out_valid", {31'd0, out_valid}, 32'd0);
      chk("done_abort_mismatch",  {31'd0, mismatch},  32'd0);
      chk("done_abort_out_data",  {24'd0, out_data},  {24'd0, exp_q.pop_front()});
      chk("done_abort_in_ready",  {31'd0, in_ready},  32'd1);
      tick();

      // 6: async reset at c=14 of 66, then 99 round trips
      xfer(8'h66, -1, -1, 14, lat);
      chk("arst_in_ready",  {31'd0, in_ready},  32'd1);
      chk("arst_ser_out",   {31'd0, ser_out},   32'd0);
      chk("arst_shift_en",  {31'd0, shift_en},  32'd0);
      chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_out_data",  {24'd0, out_data},  32'd0);
      chk("arst_mismatch",  {31'd0, mismatch},  32'd0);
      chk("arst_busy",      {31'd0, busy},      32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (12) tick();
      exp_q.push_back(8'h99);
      xfer(8'h99, -1, -1, -1, lat);
      chk("99_latency", lat, LAT);
      chk("99_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
      chk("99_mismatch", {31'd0, mismatch}, 32'd0);
      tick();

      // ---------------- report ----------------
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
